// File: rtl/chess_clock_core.sv
// Two-player chess clock timekeeping: turn FSM, one-second prescaler and
// per-player MM:SS countdown with out-of-time flags. All outputs are registered.
module chess_clock_core #(
  parameter int CLK_DIV     = 100000000,
  parameter int DEFAULT_MIN = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_pause,
  input  logic       btn_p1,
  input  logic       btn_p2,
  input  logic       load,
  input  logic [4:0] init_min,
  output logic [4:0] min1,
  output logic [5:0] seg1,
  output logic [4:0] min2,
  output logic [5:0] seg2,
  output logic       turn,
  output logic       running,
  output logic       flag1,
  output logic       flag2
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [4:0]    DEF_MIN   = 5'(DEFAULT_MIN);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN_P1 = 3'd1,
    RUN_P2 = 3'd2,
    PAUSE  = 3'd3,
    FLAG1  = 3'd4,
    FLAG2  = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [4:0]    min1_n, min2_n, act_min, dec_min, load_min;
  logic [5:0]    seg1_n, seg2_n, act_seg, dec_seg;
  logic          turn_n, running_n, flag1_n, flag2_n;
  logic          in_run, tick, hit_zero;

  // Datapath: decrement of whichever clock belongs to the running player.
  always_comb begin
    in_run   = (state == RUN_P1) || (state == RUN_P2);
    tick     = in_run && (presc == PRESC_MAX);
    act_min  = (state == RUN_P2) ? min2 : min1;
    act_seg  = (state == RUN_P2) ? seg2 : seg1;
    dec_min  = act_min;
    dec_seg  = act_seg;
    if (act_seg != 6'd0) begin
      dec_seg = act_seg - 6'd1;
    end else if (act_min != 5'd0) begin
      dec_min = act_min - 5'd1;
      dec_seg = 6'd59;
    end
    hit_zero = tick && (dec_min == 5'd0) && (dec_seg == 6'd0);
    load_min = (init_min == 5'd0) ? 5'd1 : init_min;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      presc   <= '0;
      min1    <= DEF_MIN;
      seg1    <= 6'd0;
      min2    <= DEF_MIN;
      seg2    <= 6'd0;
      turn    <= 1'b0;
      running <= 1'b0;
      flag1   <= 1'b0;
      flag2   <= 1'b0;
    end else begin
      state   <= state_n;
      presc   <= presc_n;
      min1    <= min1_n;
      seg1    <= seg1_n;
      min2    <= min2_n;
      seg2    <= seg2_n;
      turn    <= turn_n;
      running <= running_n;
      flag1   <= flag1_n;
      flag2   <= flag2_n;
    end
  end

  // Priority: flag on tick > load > start_pause > active player's button.
  always_comb begin
    state_n = state;
    presc_n = in_run ? (tick ? '0 : presc + PW'(1)) : '0;
    min1_n  = min1;
    seg1_n  = seg1;
    min2_n  = min2;
    seg2_n  = seg2;
    turn_n  = turn;
    flag1_n = flag1;
    flag2_n = flag2;

    // The tick decrement lands on the outgoing player even if a switch follows.
    if (tick) begin
      if (state == RUN_P2) begin
        min2_n = dec_min;
        seg2_n = dec_seg;
      end else begin
        min1_n = dec_min;
        seg1_n = dec_seg;
      end
    end

    if (hit_zero) begin
      presc_n = '0;
      if (state == RUN_P2) begin
        state_n = FLAG2;
        flag2_n = 1'b1;
      end else begin
        state_n = FLAG1;
        flag1_n = 1'b1;
      end
    end else if (load) begin
      state_n = IDLE;
      presc_n = '0;
      min1_n  = load_min;
      seg1_n  = 6'd0;
      min2_n  = load_min;
      seg2_n  = 6'd0;
      turn_n  = 1'b0;
      flag1_n = 1'b0;
      flag2_n = 1'b0;
    end else if (start_pause) begin
      case (state)
        IDLE: begin
          state_n = RUN_P1;
          turn_n  = 1'b0;
          presc_n = '0;
        end
        RUN_P1, RUN_P2: begin
          state_n = PAUSE;
          presc_n = '0;
        end
        PAUSE: begin
          state_n = turn ? RUN_P2 : RUN_P1;
          presc_n = '0;
        end
        default: state_n = state;
      endcase
    end else if ((state == RUN_P1) && btn_p1) begin
      state_n = RUN_P2;
      turn_n  = 1'b1;
      presc_n = '0;
    end else if ((state == RUN_P2) && btn_p2) begin
      state_n = RUN_P1;
      turn_n  = 1'b0;
      presc_n = '0;
    end

    running_n = (state_n == RUN_P1) || (state_n == RUN_P2);
  end

endmodule
